// File: rtl/fsm_mealy_moore.sv
// Paired "101" serial detectors (Mealy and Moore) watching one bit stream.
// Define FSM_OVERLAP_EN for overlapping detection; undefined gives non-overlapping.

module fsm_mealy (
    input  logic clk,
    input  logic reset,
    input  logic X,
    output logic Q
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StS1   = 2'b01,
        StS10  = 2'b10
    } mealy_state_e;

    mealy_state_e r_state;
    mealy_state_e w_state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StIdle;
        Q            = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_state_next = X ? StS1 : StIdle;
            end
            StS1: begin
                w_state_next = X ? StS1 : StS10;
            end
            StS10: begin
                // Detection is combinational on X; reset gates it so Q is low in reset.
                Q = X & reset;
`ifdef FSM_OVERLAP_EN
                w_state_next = X ? StS1 : StIdle;
`else
                w_state_next = StIdle;
`endif
            end
            default: begin
                w_state_next = StIdle;
                Q            = 1'b0;
            end
        endcase
    end

endmodule

module fsm_moore (
    input  logic clk,
    input  logic reset,
    input  logic X,
    output logic Q
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StS1   = 2'b01,
        StS10  = 2'b10,
        StS101 = 2'b11
    } moore_state_e;

    moore_state_e r_state;
    moore_state_e w_state_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = StIdle;
        unique case (r_state)
            StIdle: begin
                w_state_next = X ? StS1 : StIdle;
            end
            StS1: begin
                w_state_next = X ? StS1 : StS10;
            end
            StS10: begin
                w_state_next = X ? StS101 : StIdle;
            end
            StS101: begin
`ifdef FSM_OVERLAP_EN
                w_state_next = X ? StS1 : StS10;
`else
                w_state_next = X ? StS1 : StIdle;
`endif
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Output decodes the state register only; no path from X.
    always_comb begin
        Q = (r_state == StS101);
    end

endmodule

module fsm_mealy_moore (
    input  logic clk,
    input  logic reset,
    input  logic X,
    output logic Q_mealy,
    output logic Q_moore
);

    fsm_mealy u_mealy (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Q     (Q_mealy)
    );

    fsm_moore u_moore (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Q     (Q_moore)
    );

endmodule

// File: tb/tb_fsm_mealy_moore.sv
// Self-checking bench for fsm_mealy_moore: directed streams plus random stream
// against a bit-history reference model.

module tb_fsm_mealy_moore;

    logic clk;
    logic reset;
    logic X;
    logic Q_mealy;
    logic Q_moore;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits sampled since reset (or since last consumed detect).
    logic hist[$];
    logic exp_moore;
    int   mealy_pulses;
    int   moore_pulses;
    int   edge_idx;
    int   moore_edges[$];

`ifdef FSM_OVERLAP_EN
    localparam bit Overlap = 1'b1;
    localparam int ExpPulses = 2;
`else
    localparam bit Overlap = 1'b0;
    localparam int ExpPulses = 1;
`endif

    fsm_mealy_moore dut (
        .clk     (clk),
        .reset   (reset),
        .X       (X),
        .Q_mealy (Q_mealy),
        .Q_moore (Q_moore)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic ends_101(input logic x);
        int n;
        n = hist.size();
        if (n < 2) return 1'b0;
        return hist[n-2] && !hist[n-1] && x;
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        exp_moore = 1'b0;
    endtask

    // Drive X mid-cycle and check both outputs before the edge.
    task automatic set_x(input logic x);
        X = x;
        #1;
        check("mealy_pre", Q_mealy, ends_101(x));
        check("moore_pre", Q_moore, exp_moore);
        if (Q_mealy) mealy_pulses++;
    endtask

    task automatic clock_edge();
        logic det;
        @(posedge clk);
        det = ends_101(X);
        hist.push_back(X);
        exp_moore = det;
        if (det && !Overlap) hist.delete();
        edge_idx++;
        #1;
        check("moore_post", Q_moore, exp_moore);
        check("mealy_post", Q_mealy, ends_101(X));
        if (Q_moore) begin
            moore_pulses++;
            moore_edges.push_back(edge_idx);
        end
    endtask

    task automatic step(input logic x);
        @(negedge clk);
        set_x(x);
        clock_edge();
    endtask

    // Reset asserted after a negedge, held low across n_edges rising edges.
    task automatic reset_pulse(input int n_edges);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        check("rst_mealy", Q_mealy, 1'b0);
        check("rst_moore", Q_moore, 1'b0);
        X = 1'b1;
        #1;
        check("rst_mealy_x1", Q_mealy, 1'b0);
        for (int i = 0; i < n_edges; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_mealy", Q_mealy, 1'b0);
            check("rst_hold_moore", Q_moore, 1'b0);
        end
        #1;
        reset = 1'b1;
        X = 1'b0;
        #1;
    endtask

    initial begin
        logic b;
        reset = 1'b0;
        X = 1'b0;
        edge_idx = 0;
        mealy_pulses = 0;
        moore_pulses = 0;
        model_clear();

        // Power-up
        repeat (2) @(posedge clk);
        #1;
        check("por_mealy", Q_mealy, 1'b0);
        check("por_moore", Q_moore, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step(1'b0);

        // 0,1,1 then reset held over two edges
        step(1'b0);
        step(1'b1);
        step(1'b1);
        reset_pulse(2);

        // 1,0,1 single detect
        mealy_pulses = 0;
        moore_pulses = 0;
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        check("single_mealy_cnt", mealy_pulses == 1, 1'b1);
        check("single_moore_cnt", moore_pulses == 1, 1'b1);

        // 1,0,1,0,1 overlap behaviour
        reset_pulse(1);
        mealy_pulses = 0;
        moore_pulses = 0;
        moore_edges.delete();
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b0);
        check("ovl_mealy_cnt", mealy_pulses == ExpPulses, 1'b1);
        check("ovl_moore_cnt", moore_pulses == ExpPulses, 1'b1);
        if (moore_edges.size() == 2) begin
            check("ovl_moore_gap", (moore_edges[1] - moore_edges[0]) == 2, 1'b1);
        end

        // Reset mid-sequence between edges
        step(1'b0);
        step(1'b1);
        step(1'b0);
        reset_pulse(0);
        mealy_pulses = 0;
        moore_pulses = 0;
        step(1'b1);
        step(1'b0);
        check("midrst_mealy_cnt", mealy_pulses == 0, 1'b1);
        check("midrst_moore_cnt", moore_pulses == 0, 1'b1);

        // Mealy glitch: in S10, X 1->0 within one cycle
        reset_pulse(0);
        step(1'b1);
        step(1'b0);
        @(negedge clk);
        set_x(1'b1);
        check("glitch_mealy_hi", Q_mealy, 1'b1);
        #1;
        set_x(1'b0);
        check("glitch_mealy_lo", Q_mealy, 1'b0);
        check("glitch_moore", Q_moore, 1'b0);
        clock_edge();

        // Random stream with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) begin
                reset_pulse($urandom_range(1));
            end
            b = ($urandom_range(99) < 55);
            step(b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
